// File: rtl/uart_pkg.sv
// uart_pkg: shared byte type and arbiter FSM state encoding.
package uart_pkg;
   typedef logic [7:0] byte_t;
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer.
module rr_arbiter #(
   parameter int NumClients = 4,
   parameter int IdxW = $clog2(NumClients)
) (
   input  logic [NumClients-1:0] i_req,
   input  logic [IdxW-1:0]       i_ptr,
   output logic [NumClients-1:0] o_gnt,
   output logic [IdxW-1:0]       o_idx,
   output logic                  o_any
);
   localparam logic [IdxW:0] NumL = (IdxW+1)'(NumClients);
   logic [2*NumClients-1:0] w_dbl;
   logic [IdxW-1:0]         w_off;
   logic [IdxW:0]           w_sum;
   // Rotate so the pointer lands at bit 0, then take the lowest set offset.
   assign w_dbl = {i_req, i_req} >> i_ptr;
   always_comb begin
      w_off = '0;
      for (int k = NumClients-1; k >= 0; k--)
         if (w_dbl[k]) w_off = IdxW'(k);
   end
   assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
   assign o_idx = w_sum >= NumL ? IdxW'(w_sum - NumL) : w_sum[IdxW-1:0];
   assign o_any = |i_req;
   assign o_gnt = o_any ? NumClients'(1) << o_idx : '0;
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: locks one byte-stream client onto the UART transmitter until last byte or burst cap.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NumClients = 4,
   parameter int MaxBurst = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NumClients-1:0]   req_valid_i,
   input  byte_t [NumClients-1:0]  req_data_i,
   input  logic [NumClients-1:0]   req_last_i,
   output logic [NumClients-1:0]   req_ready_o,
   output logic                    tx_valid_o,
   output byte_t                   tx_data_o,
   input  logic                    tx_ready_i,
   output logic [NumClients-1:0]   grant_o,
   output logic                    busy_o
);
   localparam int IdxW = $clog2(NumClients);
   localparam int CntW = $clog2(MaxBurst+1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxBurst);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(NumClients-1);
   state_e                r_state = IDLE;
   logic [IdxW-1:0]       r_rr_ptr = '0;
   logic [IdxW-1:0]       r_gnt_idx = '0;
   logic [NumClients-1:0] r_grant = '0;
   logic [CntW-1:0]       r_burst_cnt = '0;
   logic [NumClients-1:0] w_arb_gnt;
   logic [IdxW-1:0]       w_arb_idx;
   logic                  w_arb_any;
   logic                  w_xfer;
   logic                  w_release;
   logic [CntW-1:0]       w_cnt_nxt;
   logic [IdxW-1:0]       w_ptr_nxt;
   rr_arbiter #(.NumClients(NumClients), .IdxW(IdxW)) u_arb (
      .i_req(req_valid_i),
      .i_ptr(r_rr_ptr),
      .o_gnt(w_arb_gnt),
      .o_idx(w_arb_idx),
      .o_any(w_arb_any)
   );
   assign busy_o      = r_state == LOCKED;
   assign grant_o     = busy_o ? r_grant : '0;
   assign tx_valid_o  = busy_o && req_valid_i[r_gnt_idx];
   assign tx_data_o   = busy_o ? req_data_i[r_gnt_idx] : '0;
   assign req_ready_o = busy_o && tx_ready_i ? r_grant : '0;
   assign w_xfer      = tx_valid_o && tx_ready_i;
   assign w_cnt_nxt   = r_burst_cnt + 1'b1;
   // Last and burst cap share one release path, so the pointer moves once.
   assign w_release   = w_xfer && (req_last_i[r_gnt_idx] || w_cnt_nxt == CntMax);
   assign w_ptr_nxt   = r_gnt_idx == IdxMax ? '0 : r_gnt_idx + 1'b1;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_gnt_idx   <= '0;
         r_grant     <= '0;
      end else if (r_state == IDLE) begin
         if (w_arb_any) begin
            r_state     <= LOCKED;
            r_gnt_idx   <= w_arb_idx;
            r_grant     <= w_arb_gnt;
            r_burst_cnt <= '0;
         end
      end else if (w_xfer) begin
         r_burst_cnt <= w_cnt_nxt;
         if (w_release) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_ptr_nxt;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed checks of grant order, burst cap, owner stall and reset.
module tb_uart_tx_arb;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] valid = '0;
   logic [N-1:0][7:0] data = '0;
   logic [N-1:0] last = '0;
   logic [N-1:0] ready;
   logic tx_valid;
   logic [7:0] tx_data;
   logic txr = 1'b0;
   logic [N-1:0] grant;
   logic busy;
   int n_cmp = 0;
   int n_bad = 0;
   uart_tx_arb #(.NumClients(N), .MaxBurst(4)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data),
      .req_last_i(last), .req_ready_o(ready), .tx_valid_o(tx_valid),
      .tx_data_o(tx_data), .tx_ready_i(txr), .grant_o(grant), .busy_o(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      n_cmp++;
      assert ($onehot0(grant) && (ready & ~grant) == '0) else begin
         n_bad++;
         $error("FAIL onehot_ready: observed grant %b ready %b expected one-hot grant covering ready", grant, ready);
      end
   end
   initial begin
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_txv", tx_valid, 0);
      chk("rst_txd", tx_data, 0);
      chk("rst_ready", ready, 0);
      chk("rst_ptr", dut.r_rr_ptr, 0);
      valid[2] = 1'b1;
      data[2] = 8'h41;
      #1;
      chk("single_idle", grant, 0);
      step();
      chk("single_grant", grant, 4'b0100);
      chk("single_busy", busy, 1);
      chk("single_txv", tx_valid, 1);
      chk("single_d41", tx_data, 8'h41);
      chk("single_nordy", ready, 0);
      step();
      chk("single_hold41", tx_data, 8'h41);
      txr = 1'b1;
      #1;
      chk("single_rdy", ready, 4'b0100);
      step();
      data[2] = 8'h42;
      last[2] = 1'b1;
      txr = 1'b0;
      #1;
      chk("single_d42", tx_data, 8'h42);
      chk("single_grant2", grant, 4'b0100);
      step();
      txr = 1'b1;
      #1;
      chk("single_rdy2", ready, 4'b0100);
      step();
      valid = '0;
      last = '0;
      #1;
      chk("single_done_busy", busy, 0);
      chk("single_done_grant", grant, 0);
      chk("single_ptr3", dut.r_rr_ptr, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("cont_ptr0", dut.r_rr_ptr, 0);
      valid = '1;
      last = '1;
      for (int i = 0; i < N; i++) data[i] = 8'hA0 + 8'(i);
      #1;
      for (int i = 0; i < N; i++) begin
         chk("cont_idle", grant, 0);
         step();
         chk("cont_grant", grant, 32'(1) << i);
         chk("cont_data", tx_data, 8'hA0 + 8'(i));
         step();
      end
      valid = '0;
      #1;
      chk("cont_ptr_wrap", dut.r_rr_ptr, 0);
      last = 4'b1000;
      valid[1] = 1'b1;
      valid[3] = 1'b1;
      data[3] = 8'h33;
      data[1] = 8'h10;
      #1;
      step();
      for (int k = 0; k < 4; k++) begin
         data[1] = 8'h10 + 8'(k);
         #1;
         chk("cap_grant1", grant, 4'b0010);
         chk("cap_data", tx_data, 8'h10 + 8'(k));
         step();
      end
      chk("cap_released", busy, 0);
      chk("cap_ptr2", dut.r_rr_ptr, 2);
      step();
      chk("cap_grant3", grant, 4'b1000);
      chk("cap_data33", tx_data, 8'h33);
      step();
      valid[3] = 1'b0;
      #1;
      chk("cap_idle2", busy, 0);
      step();
      data[1] = 8'h14;
      last[1] = 1'b1;
      #1;
      chk("cap_resume", grant, 4'b0010);
      chk("cap_resume_data", tx_data, 8'h14);
      step();
      valid = '0;
      last = '0;
      #1;
      chk("cap_ptr_after", dut.r_rr_ptr, 2);
      valid[2] = 1'b1;
      #1;
      step();
      for (int k = 0; k < 4; k++) begin
         data[2] = 8'h50 + 8'(k);
         last[2] = (k == 3);
         #1;
         chk("coin_grant", grant, 4'b0100);
         step();
      end
      valid = '0;
      last = '0;
      #1;
      chk("coin_busy", busy, 0);
      chk("coin_ptr3", dut.r_rr_ptr, 3);
      valid[0] = 1'b1;
      data[0] = 8'hC0;
      valid[1] = 1'b1;
      data[1] = 8'hD1;
      last[1] = 1'b1;
      #1;
      step();
      chk("stall_grant", grant, 4'b0001);
      chk("stall_c0", tx_data, 8'hC0);
      step();
      for (int k = 0; k < 5; k++) begin
         valid[0] = 1'b0;
         data[1] = 8'hE0 + 8'(k);
         #1;
         chk("stall_hold", grant, 4'b0001);
         chk("stall_txv", tx_valid, 0);
         chk("stall_rdy", ready, 4'b0001);
         step();
      end
      valid[0] = 1'b1;
      data[0] = 8'hC1;
      last[0] = 1'b1;
      #1;
      chk("stall_resume_v", tx_valid, 1);
      chk("stall_resume_d", tx_data, 8'hC1);
      step();
      valid[0] = 1'b0;
      last[0] = 1'b0;
      data[1] = 8'hD1;
      #1;
      chk("stall_rel", busy, 0);
      chk("stall_ptr1", dut.r_rr_ptr, 1);
      step();
      chk("stall_next", grant, 4'b0010);
      chk("stall_next_d", tx_data, 8'hD1);
      step();
      valid = '0;
      last = '0;
      #1;
      valid[2] = 1'b1;
      data[2] = 8'h60;
      step();
      chk("rstm_grant", grant, 4'b0100);
      step();
      data[2] = 8'h61;
      step();
      rst = 1'b1;
      #1;
      step();
      chk("rstm_grant0", grant, 0);
      chk("rstm_txv", tx_valid, 0);
      chk("rstm_busy", busy, 0);
      chk("rstm_ptr", dut.r_rr_ptr, 0);
      rst = 1'b0;
      valid = '0;
      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
